// File: rtl/pwm_generator_n.sv
// Parametrised PWM generator: clock-enable prescaler, period counter, duty latched at period boundaries.
// Optional duty slew limiting when PWM_SLEW_LIMIT_EN is defined (default build: duty follows target directly).
module pwm_generator_n #(
    parameter int WIDTH     = 10,
    parameter int PERIOD    = 530,
    parameter int PRESCALE  = 64,
    parameter int OFFSET    = 250,
    parameter int DEADZONE  = 12,
    parameter int NEG_EN    = 0,
    parameter int RAMP_STEP = 8
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             enable,
    input  logic [WIDTH-1:0] pwm_in,
    output logic             pwm_out,
    output logic             dir_out,
    output logic             period_start
);

    localparam int PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW     = $clog2(PERIOD);
    localparam int DW     = $clog2(PERIOD + 1);
    localparam int TW_MIN = WIDTH + $clog2(OFFSET + 1) + 1;
    localparam int TW     = (TW_MIN > DW) ? TW_MIN : DW + 1;

    if ((PERIOD < 2) || (PRESCALE < 1) || (RAMP_STEP < 1)) begin : g_bad_params
        $error("pwm_generator_n: PERIOD must be >= 2, PRESCALE and RAMP_STEP >= 1");
    end

    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] duty_q, duty_d;
    logic          pwm_q, pwm_d;
    logic          dir_q, dir_d;
    logic          start_q, start_d;

    logic             sign;
    logic [WIDTH-1:0] mag;
    logic [TW-1:0]    mag_ext;
    logic [TW-1:0]    sum;
    logic [DW-1:0]    target;
    logic [DW-1:0]    duty_new;
    logic             dir_new;
    logic             tick;
    logic             boundary;
    logic [DW:0]      cnt_inc;

    // Magnitude of the demand, then dead zone, start offset and clamp to a full period.
    always_comb begin : demand
        sign    = (NEG_EN != 0) ? pwm_in[WIDTH-1] : 1'b0;
        mag     = sign ? (~pwm_in + WIDTH'(1)) : pwm_in;
        mag_ext = TW'(mag);
        sum     = mag_ext + TW'(OFFSET);
        if (mag_ext <= TW'(DEADZONE)) begin
            target = '0;
        end else if (sum >= TW'(PERIOD)) begin
            target = DW'(PERIOD);
        end else begin
            target = DW'(sum);
        end
    end

`ifdef PWM_SLEW_LIMIT_EN
    logic [DW-1:0] goal;
    logic [DW-1:0] diff;

    // A sign reversal first ramps the old direction down to zero before dir_out may flip.
    always_comb begin : slew
        goal    = target;
        dir_new = sign;
        diff    = '0;
        if ((sign != dir_q) && (duty_q != '0)) begin
            goal    = '0;
            dir_new = dir_q;
        end
        if (goal >= duty_q) begin
            diff     = goal - duty_q;
            duty_new = (int'(diff) > RAMP_STEP) ? duty_q + DW'(RAMP_STEP) : goal;
        end else begin
            diff     = duty_q - goal;
            duty_new = (int'(diff) > RAMP_STEP) ? duty_q - DW'(RAMP_STEP) : goal;
        end
    end
`else
    always_comb begin : direct
        duty_new = target;
        dir_new  = sign;
    end
`endif

    always_comb begin : next_state
        tick      = (pre_cnt_q == PW'(PRESCALE - 1));
        boundary  = (cnt_q == CW'(PERIOD - 1));
        cnt_inc   = (DW + 1)'(cnt_q) + (DW + 1)'(1);
        pre_cnt_d = tick ? '0 : pre_cnt_q + PW'(1);
        cnt_d     = cnt_q;
        duty_d    = duty_q;
        dir_d     = dir_q;
        start_d   = 1'b0;
        pwm_d     = pwm_q & enable;
        if (tick) begin
            if (boundary) begin
                cnt_d   = '0;
                duty_d  = duty_new;
                dir_d   = dir_new;
                start_d = 1'b1;
                pwm_d   = enable && (duty_new != '0);
            end else begin
                cnt_d = cnt_q + CW'(1);
                pwm_d = enable && (cnt_inc < {1'b0, duty_q});
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pre_cnt_q <= '0;
            cnt_q     <= '0;
            duty_q    <= '0;
            pwm_q     <= 1'b0;
            dir_q     <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            cnt_q     <= cnt_d;
            duty_q    <= duty_d;
            pwm_q     <= pwm_d;
            dir_q     <= dir_d;
            start_q   <= start_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign dir_out      = dir_q;
    assign period_start = start_q;

endmodule
